nn_neuron_sequencer: RTL and testbench

Controller that sequences the shared single-cycle ALU to evaluate one neuron: y = step(sum(x[i]*w[i])). It fetches input/weight pairs from a dual-output operand memory and issues multiply, add and set-if-non-negative ALU operations in order. It accumulates the dot product in an internal register and reports the pre-activation sum and the activation bit. It sits between the layer-level control FSM and the ALU execution unit.

---
 rtl/nn_neuron_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_nn_neuron_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_neuron_sequencer.sv
// nn_neuron_sequencer
//   Drives a shared single-cycle ALU to evaluate one neuron:
//   y = step(sum(x[i] * w[i])). Operand pairs come from a dual-output memory
//   with one cycle of read latency. The dot product is accumulated internally.
//   After the last element, a set-if-non-negative operation turns the sum
//   into the activation bit.
//
//   Optional build macro: NN_SEQ_BIAS_EN
//     This macro adds a bias input, which is sampled together with start.
//     It also adds a BIAS state, which folds the bias into the accumulator
//     before the activation step.
//
//   State table
//     state   | meaning
//     --------+----------------------------------------------------------
//     S_IDLE  | waiting for start; latches count/base_addr, clears acc/idx
//     S_FETCH | issue operand read at base_addr + idx (wraps mod 2^AW)
//     S_WAIT  | memory latency cycle; x/w captured at the end of it
//     S_MUL   | ALU multiply x * w into the product register
//     S_ACC   | ALU add acc + product into acc, advance idx
//     S_BIAS  | (NN_SEQ_BIAS_EN only) ALU add acc + bias into acc
//     S_ACT   | ALU set-if-non-negative on acc; publish result and act
//     S_DONE  | one-cycle done pulse, back to idle

module nn_neuron_sequencer #(
    parameter int          nBits       = 32,
    parameter int          AW          = 8,
    parameter logic [2:0]  SEQ_IDLE_OP = 3'b111
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW-1:0]    count,
    input  logic [AW-1:0]    base_addr,
`ifdef NN_SEQ_BIAS_EN
    input  logic [nBits-1:0] bias,
`endif
    output logic             busy,
    output logic             done,
    output logic             mem_rd_en,
    output logic [AW-1:0]    mem_addr,
    input  logic [nBits-1:0] mem_x,
    input  logic [nBits-1:0] mem_w,
    output logic [2:0]       alu_ctrl,
    output logic [nBits-1:0] alu_src_a,
    output logic [nBits-1:0] alu_src_b,
    input  logic [nBits-1:0] alu_result,
    output logic [nBits-1:0] result,
    output logic             act
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_MUL  = 3'b001;
    localparam logic [2:0] OP_SGEZ = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_MUL   = 3'd3,
        S_ACC   = 3'd4,
`ifdef NN_SEQ_BIAS_EN
        S_BIAS  = 3'd7,
`endif
        S_ACT   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    // The state after the last accumulate (or after IDLE when N=0).
`ifdef NN_SEQ_BIAS_EN
    localparam state_t S_POST_ACC = S_BIAS;
`else
    localparam state_t S_POST_ACC = S_ACT;
`endif

    state_t             state_q;
    state_t             state_d;

    logic [AW-1:0]      cnt_q;
    logic [AW-1:0]      base_q;
    logic [AW-1:0]      idx_q;
    logic [nBits-1:0]   acc_q;
    logic [nBits-1:0]   x_q;
    logic [nBits-1:0]   w_q;
    logic [nBits-1:0]   prod_q;
    logic [nBits-1:0]   result_q;
    logic               act_q;
`ifdef NN_SEQ_BIAS_EN
    logic [nBits-1:0]   bias_q;
`endif

    // The accumulate step of the final pair. ACC is only entered with N >= 1,
    // so cnt_q - 1 never underflows when this flag is used.
    logic               last_elem;
    assign last_elem = (idx_q == (cnt_q - AW'(1)));

    assign result = result_q;
    assign act    = act_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and Moore outputs. Reset therefore forces idle outputs at once.
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        alu_ctrl  = SEQ_IDLE_OP;
        alu_src_a = '0;
        alu_src_b = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (count != '0) ? S_FETCH : S_POST_ACC;
                end
            end

            S_FETCH: begin
                busy      = 1'b1;
                mem_rd_en = 1'b1;
                mem_addr  = base_q + idx_q;
                state_d   = S_WAIT;
            end

            S_WAIT: begin
                busy    = 1'b1;
                state_d = S_MUL;
            end

            S_MUL: begin
                busy      = 1'b1;
                alu_ctrl  = OP_MUL;
                alu_src_a = x_q;
                alu_src_b = w_q;
                state_d   = S_ACC;
            end

            S_ACC: begin
                busy      = 1'b1;
                alu_ctrl  = OP_ADD;
                alu_src_a = acc_q;
                alu_src_b = prod_q;
                state_d   = last_elem ? S_POST_ACC : S_FETCH;
            end

`ifdef NN_SEQ_BIAS_EN
            S_BIAS: begin
                busy      = 1'b1;
                alu_ctrl  = OP_ADD;
                alu_src_a = acc_q;
                alu_src_b = bias_q;
                state_d   = S_ACT;
            end
`endif

            S_ACT: begin
                busy      = 1'b1;
                alu_ctrl  = OP_SGEZ;
                alu_src_a = acc_q;
                state_d   = S_DONE;
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath registers: each state updates only the registers it owns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            base_q   <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            x_q      <= '0;
            w_q      <= '0;
            prod_q   <= '0;
            result_q <= '0;
            act_q    <= 1'b0;
`ifdef NN_SEQ_BIAS_EN
            bias_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cnt_q  <= count;
                        base_q <= base_addr;
                        acc_q  <= '0;
                        idx_q  <= '0;
`ifdef NN_SEQ_BIAS_EN
                        bias_q <= bias;
`endif
                    end
                end

                S_WAIT: begin
                    x_q <= mem_x;
                    w_q <= mem_w;
                end

                S_MUL: begin
                    prod_q <= alu_result;
                end

                S_ACC: begin
                    acc_q <= alu_result;
                    idx_q <= idx_q + AW'(1);
                end

`ifdef NN_SEQ_BIAS_EN
                S_BIAS: begin
                    acc_q <= alu_result;
                end
`endif

                S_ACT: begin
                    result_q <= acc_q;
                    act_q    <= alu_result[0];
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_neuron_sequencer.sv
// Testbench for nn_neuron_sequencer: table-driven dot-product vectors,
// a behavioural ALU and operand memory, plus hand-written corner sequences.
// Build with +define+NN_SEQ_BIAS_EN to also exercise the bias step.

module tb_nn_neuron_sequencer;

    localparam int NB = 32;
    localparam int AW = 8;
`ifdef NN_SEQ_BIAS_EN
    localparam int BIAS_LAT = 1;
`else
    localparam int BIAS_LAT = 0;
`endif

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [AW-1:0]   count;
    logic [AW-1:0]   base_addr;
`ifdef NN_SEQ_BIAS_EN
    logic [NB-1:0]   bias;
`endif
    logic            busy;
    logic            done;
    logic            mem_rd_en;
    logic [AW-1:0]   mem_addr;
    logic [NB-1:0]   mem_x;
    logic [NB-1:0]   mem_w;
    logic [2:0]      alu_ctrl;
    logic [NB-1:0]   alu_src_a;
    logic [NB-1:0]   alu_src_b;
    logic [NB-1:0]   alu_result;
    logic [NB-1:0]   result;
    logic            act;

    logic [NB-1:0]   xm [256];
    logic [NB-1:0]   wm [256];

    int n_chk  = 0;
    int n_fail = 0;

    nn_neuron_sequencer #(.nBits(NB), .AW(AW), .SEQ_IDLE_OP(3'b111)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .count     (count),
        .base_addr (base_addr),
`ifdef NN_SEQ_BIAS_EN
        .bias      (bias),
`endif
        .busy      (busy),
        .done      (done),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_x     (mem_x),
        .mem_w     (mem_w),
        .alu_ctrl  (alu_ctrl),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_result(alu_result),
        .result    (result),
        .act       (act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU
    always_comb begin
        case (alu_ctrl)
            3'b000:  alu_result = alu_src_a + alu_src_b;
            3'b001:  alu_result = alu_src_a * alu_src_b;
            3'b010:  alu_result = {31'b0, ~alu_src_a[31]};
            default: alu_result = alu_src_a;
        endcase
    end

    // Operand memory with one cycle of read latency
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_x <= xm[mem_addr];
            mem_w <= wm[mem_addr];
        end
    end

    typedef struct {
        int               n;
        logic [AW-1:0]    base;
        logic [3:0][31:0] x;
        logic [3:0][31:0] w;
        logic [31:0]      bias_v;
        logic [31:0]      exp_res;
        logic             exp_act;
        int               exp_lat;
        bit               disturb;
    } vec_t;

    vec_t vecs [6];
    int   n_vecs;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},   {31'b0, busy},      32'd0);
        check({tag, "_done"},   {31'b0, done},      32'd0);
        check({tag, "_rd_en"},  {31'b0, mem_rd_en}, 32'd0);
        check({tag, "_addr"},   {24'b0, mem_addr},  32'd0);
        check({tag, "_ctrl"},   {29'b0, alu_ctrl},  32'd7);
        check({tag, "_src_a"},  alu_src_a,          32'd0);
        check({tag, "_src_b"},  alu_src_b,          32'd0);
        check({tag, "_result"}, result,             32'd0);
        check({tag, "_act"},    {31'b0, act},       32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int          edges;
        bit          got_done;
        int          rd_cnt;
        int          extra_done;
        logic [2:0]  trace [$];
        logic [2:0]  exp_tr [$];
        bit          tr_ok;
        for (int i = 0; i < v.n; i++) begin
            xm[AW'(v.base + AW'(i))] = v.x[i];
            wm[AW'(v.base + AW'(i))] = v.w[i];
        end
        for (int i = 0; i < v.n; i++) begin
            exp_tr.push_back(3'b001);
            exp_tr.push_back(3'b000);
        end
        if (BIAS_LAT != 0) exp_tr.push_back(3'b000);
        exp_tr.push_back(3'b010);

        @(negedge clk);
        count     = AW'(v.n);
        base_addr = v.base;
`ifdef NN_SEQ_BIAS_EN
        bias      = v.bias_v;
`endif
        start     = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        edges    = 1;
        got_done = 1'b0;
        rd_cnt   = 0;
        for (int k = 0; k < 200; k++) begin
            if (mem_rd_en) begin
                check({tag, "_addr"}, {24'b0, mem_addr}, {24'b0, AW'(v.base + AW'(rd_cnt))});
                rd_cnt++;
            end
            if (alu_ctrl != 3'b111) trace.push_back(alu_ctrl);
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (v.disturb && k == 2) begin
                start     = 1'b1;
                count     = 8'd5;
                base_addr = 8'd77;
            end
            if (v.disturb && k == 4) start = 1'b0;
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, "_done_seen"}, {31'b0, got_done}, 32'd1);
        check({tag, "_latency"}, edges, v.exp_lat + BIAS_LAT);
        check({tag, "_result"}, result, v.exp_res);
        check({tag, "_act"}, {31'b0, act}, {31'b0, v.exp_act});
        check({tag, "_rd_count"}, rd_cnt, v.n);
        tr_ok = (trace.size() == exp_tr.size());
        if (tr_ok) begin
            foreach (trace[i]) if (trace[i] !== exp_tr[i]) tr_ok = 1'b0;
        end
        check({tag, "_ctrl_trace"}, {31'b0, tr_ok}, 32'd1);
        extra_done = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
        end
        check({tag, "_single_done"}, extra_done, 32'd0);
        check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        count     = '0;
        base_addr = '0;
`ifdef NN_SEQ_BIAS_EN
        bias      = '0;
`endif
        for (int i = 0; i < 256; i++) begin
            xm[i] = '0;
            wm[i] = '0;
        end

        // n, base, x, w, bias, result, act, latency(4N+2), disturb
        vecs[0] = '{3, 8'd0,   {32'd0, 32'd3, 32'd2, 32'd1}, {32'd0, 32'd6, 32'd5, 32'd4},
                    32'd0, 32'd32, 1'b1, 14, 1'b0};
        vecs[1] = '{2, 8'd10,  {32'd0, 32'd0, 32'hFFFF_FFFB, 32'd2}, {32'd0, 32'd0, 32'd4, 32'd3},
                    32'd0, 32'hFFFF_FFF2, 1'b0, 10, 1'b0};
        vecs[2] = '{0, 8'd40,  {32'd0, 32'd0, 32'd0, 32'd0}, {32'd0, 32'd0, 32'd0, 32'd0},
                    32'd0, 32'd0, 1'b1, 2, 1'b0};
        vecs[3] = '{2, 8'd255, {32'd0, 32'd0, 32'd7, 32'h4000_0000}, {32'd0, 32'd0, 32'd3, 32'd4},
                    32'd0, 32'd21, 1'b1, 10, 1'b1};
        vecs[4] = '{2, 8'd128, {32'd0, 32'd0, 32'd1, 32'h7FFF_FFFF}, {32'd0, 32'd0, 32'd1, 32'd1},
                    32'd0, 32'h8000_0000, 1'b0, 10, 1'b0};
        n_vecs = 5;
`ifdef NN_SEQ_BIAS_EN
        vecs[5] = '{1, 8'd20, {32'd0, 32'd0, 32'd0, 32'd1}, {32'd0, 32'd0, 32'd0, 32'd1},
                    32'hFFFF_FFFD, 32'hFFFF_FFFE, 1'b0, 6, 1'b0};
        n_vecs = 6;
`endif

        #3;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < n_vecs; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset during the MUL of element 1 of a three-element run.
        begin
            int  muls;
            bit  hit;
            int  late_done;
            muls = 0;
            hit  = 1'b0;
            @(negedge clk);
            count     = 8'd3;
            base_addr = 8'd0;
            start     = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            for (int k = 0; k < 40; k++) begin
                if (alu_ctrl == 3'b001) begin
                    muls++;
                    if (muls == 2) begin
                        hit = 1'b1;
                        break;
                    end
                end
                @(posedge clk);
                #1;
            end
            check("midrst_reached_mul1", {31'b0, hit}, 32'd1);
            #1;
            rst_n = 1'b0;
            #1;
            check_idle_outputs("midrst");
            @(negedge clk);
            rst_n = 1'b1;
            late_done = 0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk);
                #1;
                if (done) late_done++;
            end
            check("midrst_no_done", late_done, 32'd0);
            run_vec(vecs[0], "after_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
